// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ wclk-domain producers.
// Grants bounded bursts, stalls on wFull, and holds off throttled requesters while half full.
module async_fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 9,
  parameter int BURST_LEN = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   throttle_mask,
  input  logic              wFull,
  input  logic              wHalf_full,
  output logic              winc,
  output logic [DW-1:0]     wData,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  state_t        state_q;
  logic [IW-1:0] grant_id_q;
  logic [IW-1:0] rr_ptr_q;
  logic [BW-1:0] beat_cnt_q;

  logic [NREQ-1:0] eligible;
  logic [IW-1:0]   pick_idx_d;
  logic [IW-1:0]   cand;
  logic [DW-1:0]   req_word [NREQ];
  logic            in_grant;
  logic            sel_valid;
  logic            xfer;

  assign eligible = req_valid & ~(throttle_mask & {NREQ{wHalf_full}});

  // Scan from the far end back toward rr_ptr+1 so the last hit is the first in rotation order.
  always_comb begin
    pick_idx_d = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (eligible[cand]) begin
        pick_idx_d = cand;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*DW +: DW];
      assign req_ready[gi] = xfer && (grant_id_q == IW'(gi));
    end
  endgenerate

  assign in_grant  = (state_q == GRANT);
  assign sel_valid = req_valid[grant_id_q];
  assign xfer      = in_grant && sel_valid && !wFull;

  // Write path is combinational so the FIFO sees wFull and winc on the same edge.
  assign winc     = xfer;
  assign wData    = in_grant ? req_word[grant_id_q] : '0;
  assign grant_id = grant_id_q;
  assign busy     = in_grant;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= IW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!wFull && (|eligible)) begin
            grant_id_q <= pick_idx_d;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (!sel_valid || (xfer && beat_cnt_q == LAST_BEAT)) begin
            state_q    <= IDLE;
            rr_ptr_q   <= grant_id_q;
            beat_cnt_q <= '0;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter: a per-cycle vector table for the
// basic burst, then directed sequences; every FIFO write is matched against a scoreboard.
module tb_async_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 9;
  localparam int BURST_LEN = 4;
  localparam int IW   = 2;

  logic               wclk = 1'b0;
  logic               wrst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    throttle_mask;
  logic               wFull;
  logic               wHalf_full;
  logic               winc;
  logic [DW-1:0]      wData;
  logic [IW-1:0]      grant_id;
  logic               busy;

  async_fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(BURST_LEN)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .throttle_mask(throttle_mask), .wFull(wFull),
    .wHalf_full(wHalf_full), .winc(winc), .wData(wData), .grant_id(grant_id),
    .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int id;
    int data;
  } word_t;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic            exp_busy;
    logic            exp_winc;
    logic [DW-1:0]   exp_wdata;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cnt [NREQ];
  word_t sb_q [$];
  logic [NREQ-1:0] rdy_s;
  vec_t vt [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Producer i emits 0x101 + 0x20*i + (words it has had accepted so far).
  function automatic int word_of(input int i, input int c);
    return 'h101 + i * 'h20 + c;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(word_of(i, cnt[i]));
  endtask

  task automatic expect_word(input int id, input int c);
    word_t w;
    w.id = id;
    w.data = word_of(id, c);
    sb_q.push_back(w);
  endtask

  // Called at posedge+1; samples at the following negedge.
  task automatic to_sample();
    word_t w;
    drive_data();
    #4;
    if (winc === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: winc with wData=0x%0h grant_id=%0d, no word expected", wData, grant_id);
      end else begin
        w = sb_q.pop_front();
        check("sb_data", int'(wData), w.data);
        check("sb_grant", int'(grant_id), w.id);
        check("sb_ready", int'(req_ready), 1 << w.id);
      end
      check("winc_while_full", int'(wFull), 0);
      $display("write: id=%0d data=0x%0h", grant_id, wData);
    end
    check("ready_onehot", int'($countones(req_ready) <= 1), 1);
    rdy_s = req_ready;
  endtask

  task automatic to_next();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (rdy_s[i]) cnt[i]++;
  endtask

  task automatic tick();
    to_sample();
    to_next();
  endtask

  task automatic sb_drain(input string name);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    req_valid = '0;
    throttle_mask = '0;
    wFull = 1'b0;
    wHalf_full = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_winc", int'(winc), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_wdata", int'(wData), 0);
    check("rst_grant", int'(grant_id), 0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    rdy_s = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'b0001, 1'b0, 1'b0, 9'h000};
    vt[1] = '{4'b0001, 1'b1, 1'b1, 9'h101};
    vt[2] = '{4'b0001, 1'b1, 1'b1, 9'h102};
    vt[3] = '{4'b0001, 1'b1, 1'b1, 9'h103};
    vt[4] = '{4'b0001, 1'b1, 1'b1, 9'h104};
    vt[5] = '{4'b0001, 1'b0, 1'b0, 9'h000};
    vt[6] = '{4'b0001, 1'b1, 1'b1, 9'h105};
    vt[7] = '{4'b0000, 1'b1, 1'b0, 9'h106};
    vt[8] = '{4'b0000, 1'b0, 1'b0, 9'h000};

    req_data = '0;
    @(posedge wclk);
    #1;
    do_reset();

    // Single requester: burst of 4, arbitration gap, re-grant, then drop.
    for (int c = 0; c < 5; c++) expect_word(0, c);
    for (int i = 0; i < 9; i++) begin
      req_valid = vt[i].valid;
      to_sample();
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].exp_busy));
      check($sformatf("vec%0d_winc", i), int'(winc), int'(vt[i].exp_winc));
      check($sformatf("vec%0d_wdata", i), int'(wData), int'(vt[i].exp_wdata));
      to_next();
    end
    sb_drain("s1_drain");

    // All requesting: rotation 0,1,2,3,0 with full bursts.
    do_reset();
    req_valid = 4'b1111;
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < BURST_LEN; k++) expect_word(b % NREQ, (b / NREQ) * BURST_LEN + k);
    repeat (25) tick();
    req_valid = '0;
    repeat (2) tick();
    sb_drain("s2_drain");

    // Requester 2 stalled by wFull after its second word.
    do_reset();
    req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) expect_word(2, c);
    repeat (3) tick();
    wFull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      check("stall_winc", int'(winc), 0);
      check("stall_busy", int'(busy), 1);
      to_next();
    end
    wFull = 1'b0;
    tick();
    to_sample();
    check("stall_last_busy", int'(busy), 1);
    to_next();
    req_valid = '0;
    to_sample();
    check("stall_end_idle", int'(busy), 0);
    to_next();
    sb_drain("s3_drain");

    // Throttled requesters wait out wHalf_full.
    do_reset();
    wHalf_full = 1'b1;
    throttle_mask = 4'b0011;
    req_valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      check("thr_hold_busy", int'(busy), 0);
      to_next();
    end
    wHalf_full = 1'b0;
    to_sample();
    check("thr_release_idle", int'(busy), 0);
    to_next();
    expect_word(0, 0);
    to_sample();
    check("thr_grant_busy", int'(busy), 1);
    check("thr_grant_id", int'(grant_id), 0);
    to_next();
    req_valid = '0;
    repeat (2) tick();
    sb_drain("s4_drain");

    // Requester 1 ends early; rotation resumes above it.
    do_reset();
    req_valid = 4'b0010;
    expect_word(1, 0);
    expect_word(1, 1);
    repeat (3) tick();
    req_valid = 4'b1001;
    to_sample();
    check("drop_winc", int'(winc), 0);
    check("drop_busy", int'(busy), 1);
    to_next();
    to_sample();
    check("drop_idle", int'(busy), 0);
    to_next();
    expect_word(3, 0);
    to_sample();
    check("drop_next_busy", int'(busy), 1);
    check("drop_next_id", int'(grant_id), 3);
    to_next();
    req_valid = '0;
    repeat (2) tick();
    sb_drain("s5_drain");

    // Reset in the middle of a burst.
    do_reset();
    req_valid = 4'b0001;
    expect_word(0, 0);
    expect_word(0, 1);
    repeat (3) tick();
    drive_data();
    #1;
    check("pre_rst_winc", int'(winc), 1);
    wrst = 1'b1;
    #1;
    check("mid_rst_winc", int'(winc), 0);
    check("mid_rst_ready", int'(req_ready), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_wdata", int'(wData), 0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    rdy_s = '0;
    req_valid = 4'b1000;
    sb_drain("s6_partial_drain");
    expect_word(3, 0);
    to_sample();
    check("post_rst_idle", int'(busy), 0);
    to_next();
    to_sample();
    check("post_rst_busy", int'(busy), 1);
    check("post_rst_id", int'(grant_id), 3);
    to_next();
    req_valid = '0;
    repeat (2) tick();
    sb_drain("s6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
